// File: rtl/cnn_score_collector.sv
// CNN classifier output sink: captures one score per class per frame,
// finds the argmax with one compare per cycle, and emits one result record
// per frame together with a frame counter.

// One class channel: holds the captured score and a "captured this frame" flag.
module cnn_score_lane #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         collect_i,
  input  logic         clear_i,
  input  logic [W-1:0] tdata_i,
  input  logic         tvalid_i,
  output logic         tready_o,
  output logic         cap_o,
  output logic         flag_o,
  output logic [W-1:0] score_o
);
  logic         flag_q;
  logic [W-1:0] score_q;

  // Once captured, the channel back-pressures so a second score for the
  // same class stays upstream instead of overwriting this one.
  assign tready_o = ~reset & collect_i & ~flag_q;
  assign cap_o    = tvalid_i & tready_o;
  assign flag_o   = flag_q;
  assign score_o  = score_q;

  // Capture score and flag on handshake; flags drop when the record is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q  <= 1'b0;
      score_q <= '0;
    end else begin
      if (clear_i)    flag_q <= 1'b0;
      else if (cap_o) flag_q <= 1'b1;
      if (cap_o) score_q <= tdata_i;
    end
  end
endmodule

module cnn_score_collector #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int SIGNED_SCORES   = 1,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_0_TDATA,
  input  logic                         cnn_output_0_TVALID,
  output logic                         cnn_output_0_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_1_TDATA,
  input  logic                         cnn_output_1_TVALID,
  output logic                         cnn_output_1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_2_TDATA,
  input  logic                         cnn_output_2_TVALID,
  output logic                         cnn_output_2_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_3_TDATA,
  input  logic                         cnn_output_3_TVALID,
  output logic                         cnn_output_3_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_4_TDATA,
  input  logic                         cnn_output_4_TVALID,
  output logic                         cnn_output_4_TREADY,
  output logic [5*PIXEL_BIT_WIDTH-1:0] result_scores_TDATA,
  output logic [2:0]                   result_class_TDATA,
  output logic [PIXEL_BIT_WIDTH-1:0]   result_max_TDATA,
  output logic [FRAME_CNT_WIDTH-1:0]   result_frame_TDATA,
  output logic                         result_TVALID,
  input  logic                         result_TREADY,
  output logic                         busy
);
  localparam int W = PIXEL_BIT_WIDTH;

  typedef enum logic [1:0] {COLLECT, ARGMAX, OUT} state_e;

  state_e                     state_q;
  logic [2:0]                 best_idx_q, best_idx_d, scan_idx_q;
  logic [W-1:0]               best_val_q, best_val_d, cand;
  logic                       gt;
  logic [5*W-1:0]             res_scores_q;
  logic [2:0]                 res_class_q;
  logic [W-1:0]               res_max_q;
  logic [FRAME_CNT_WIDTH-1:0] res_frame_q, frame_q;
  logic                       vld_q;

  logic [4:0][W-1:0] tdata, score;
  logic [4:0]        tvalid, tready, cap, flag;
  logic              collect, clear;

  assign tdata  = {cnn_output_4_TDATA, cnn_output_3_TDATA, cnn_output_2_TDATA,
                   cnn_output_1_TDATA, cnn_output_0_TDATA};
  assign tvalid = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                   cnn_output_1_TVALID, cnn_output_0_TVALID};
  assign {cnn_output_4_TREADY, cnn_output_3_TREADY, cnn_output_2_TREADY,
          cnn_output_1_TREADY, cnn_output_0_TREADY} = tready;

  assign collect = (state_q == COLLECT);
  assign clear   = (state_q == OUT) & result_TREADY;

  genvar k;
  for (k = 0; k < 5; k++) begin : g_lane
    cnn_score_lane #(.W(W)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .collect_i (collect),
      .clear_i   (clear),
      .tdata_i   (tdata[k]),
      .tvalid_i  (tvalid[k]),
      .tready_o  (tready[k]),
      .cap_o     (cap[k]),
      .flag_o    (flag[k]),
      .score_o   (score[k])
    );
  end

  // Single comparator: candidate at scan_idx against the running best.
  // Strict greater-than keeps ties on the lower index.
  always_comb begin
    cand = score[scan_idx_q];
    if (SIGNED_SCORES != 0) gt = $signed(cand) > $signed(best_val_q);
    else                    gt = cand > best_val_q;
    best_idx_d = gt ? scan_idx_q : best_idx_q;
    best_val_d = gt ? cand : best_val_q;
  end

  // Frame FSM: collect five scores, scan indices 1..4, hold the record until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      best_idx_q   <= '0;
      best_val_q   <= '0;
      scan_idx_q   <= '0;
      res_scores_q <= '0;
      res_class_q  <= '0;
      res_max_q    <= '0;
      res_frame_q  <= '0;
      frame_q      <= '0;
      vld_q        <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (&(flag | cap)) begin
            state_q    <= ARGMAX;
            best_idx_q <= '0;
            best_val_q <= cap[0] ? tdata[0] : score[0];
            scan_idx_q <= 3'd1;
          end
        end
        ARGMAX: begin
          best_idx_q <= best_idx_d;
          best_val_q <= best_val_d;
          scan_idx_q <= scan_idx_q + 3'd1;
          if (scan_idx_q == 3'd4) begin
            state_q      <= OUT;
            res_scores_q <= score;
            res_class_q  <= best_idx_d;
            res_max_q    <= best_val_d;
            res_frame_q  <= frame_q;
            vld_q        <= 1'b1;
          end
        end
        OUT: begin
          if (result_TREADY) begin
            vld_q   <= 1'b0;
            frame_q <= frame_q + FRAME_CNT_WIDTH'(1);
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign result_scores_TDATA = res_scores_q;
  assign result_class_TDATA  = res_class_q;
  assign result_max_TDATA    = res_max_q;
  assign result_frame_TDATA  = res_frame_q;
  assign result_TVALID       = vld_q;
  assign busy                = (state_q != COLLECT) | (|flag);
endmodule

// File: tb/tb_cnn_score_collector.sv
// Bench for cnn_score_collector: two instances share all stimulus, one signed
// with a 16-bit frame counter, one unsigned with a 2-bit counter. Expected
// records are queued when a frame's last score is driven and checked on output.
module tb_cnn_score_collector;
  localparam int W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] td [5];
  logic [4:0] tv = '0;
  logic [4:0] trdy_a, trdy_b;
  logic rrdy = 1'b1;
  logic [5*W-1:0] sc_a, sc_b;
  logic [2:0] cl_a, cl_b;
  logic [W-1:0] mx_a, mx_b;
  logic [15:0] fr_a;
  logic [1:0] fr_b;
  logic vl_a, vl_b, busy_a, busy_b;

  typedef struct {
    logic [4:0][W-1:0] sc;
    logic [2:0] cs, cu;
    logic [W-1:0] ms, mu;
    int fr;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, frame_no = 0;

  always #5 clk = ~clk;

  cnn_score_collector #(.PIXEL_BIT_WIDTH(W), .SIGNED_SCORES(1), .FRAME_CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset),
    .cnn_output_0_TDATA(td[0]), .cnn_output_0_TVALID(tv[0]), .cnn_output_0_TREADY(trdy_a[0]),
    .cnn_output_1_TDATA(td[1]), .cnn_output_1_TVALID(tv[1]), .cnn_output_1_TREADY(trdy_a[1]),
    .cnn_output_2_TDATA(td[2]), .cnn_output_2_TVALID(tv[2]), .cnn_output_2_TREADY(trdy_a[2]),
    .cnn_output_3_TDATA(td[3]), .cnn_output_3_TVALID(tv[3]), .cnn_output_3_TREADY(trdy_a[3]),
    .cnn_output_4_TDATA(td[4]), .cnn_output_4_TVALID(tv[4]), .cnn_output_4_TREADY(trdy_a[4]),
    .result_scores_TDATA(sc_a), .result_class_TDATA(cl_a), .result_max_TDATA(mx_a),
    .result_frame_TDATA(fr_a), .result_TVALID(vl_a), .result_TREADY(rrdy), .busy(busy_a));

  cnn_score_collector #(.PIXEL_BIT_WIDTH(W), .SIGNED_SCORES(0), .FRAME_CNT_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset),
    .cnn_output_0_TDATA(td[0]), .cnn_output_0_TVALID(tv[0]), .cnn_output_0_TREADY(trdy_b[0]),
    .cnn_output_1_TDATA(td[1]), .cnn_output_1_TVALID(tv[1]), .cnn_output_1_TREADY(trdy_b[1]),
    .cnn_output_2_TDATA(td[2]), .cnn_output_2_TVALID(tv[2]), .cnn_output_2_TREADY(trdy_b[2]),
    .cnn_output_3_TDATA(td[3]), .cnn_output_3_TVALID(tv[3]), .cnn_output_3_TREADY(trdy_b[3]),
    .cnn_output_4_TDATA(td[4]), .cnn_output_4_TVALID(tv[4]), .cnn_output_4_TREADY(trdy_b[4]),
    .result_scores_TDATA(sc_b), .result_class_TDATA(cl_b), .result_max_TDATA(mx_b),
    .result_frame_TDATA(fr_b), .result_TVALID(vl_b), .result_TREADY(rrdy), .busy(busy_b));

  function automatic logic [4:0][W-1:0] mk(input logic [W-1:0] a, b, c, d, e);
    logic [4:0][W-1:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  // Reference argmax: first index holding the largest value.
  function automatic void argmax(input logic [4:0][W-1:0] s, input bit sgn,
                                 output logic [2:0] idx, output logic [W-1:0] mx);
    idx = 3'd0;
    mx  = s[0];
    for (int i = 1; i < 5; i++)
      if (sgn ? ($signed(s[i]) > $signed(mx)) : (s[i] > mx)) begin
        idx = 3'(i);
        mx  = s[i];
      end
  endfunction

  task automatic push_frame(input logic [4:0][W-1:0] s);
    exp_t e;
    e.sc = s;
    argmax(s, 1'b1, e.cs, e.ms);
    argmax(s, 1'b0, e.cu, e.mu);
    e.fr = frame_no;
    frame_no++;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All five channels valid in one cycle; the capture edge is the tick here.
  task automatic send_all(input string nm, input logic [4:0][W-1:0] s);
    for (int i = 0; i < 5; i++) td[i] = s[i];
    tv = 5'h1f;
    #1;
    total++;
    if (trdy_a !== 5'h1f || trdy_b !== 5'h1f) begin
      $display("FAIL %s tready_before: got %b/%b want 11111", nm, trdy_a, trdy_b);
      bad++;
    end
    tick();
    tv = '0;
    push_frame(s);
    total++;
    if (trdy_a !== 5'h00) begin
      $display("FAIL %s tready_after: got %b want 00000", nm, trdy_a);
      bad++;
    end
  endtask

  // Wait for the record, check latency from the last capture edge and contents.
  task automatic wait_result(input string nm, input int lat, output exp_t e);
    int n = 0;
    e = '{default: 0};
    while (!vl_a && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (vl_a !== 1'b1 || vl_b !== 1'b1 || (lat > 0 && n != lat)) begin
      $display("FAIL %s latency: got %0d cycles valid=%b/%b want %0d", nm, n, vl_a, vl_b, lat);
      bad++;
    end
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: got empty queue want a pending record", nm);
      bad++;
      return;
    end
    e = sb.pop_front();
    if (sc_a !== e.sc || cl_a !== e.cs || mx_a !== e.ms || fr_a !== e.fr[15:0]) begin
      $display("FAIL %s signed_rec: got sc=%h cls=%0d max=%h fr=%0d want sc=%h cls=%0d max=%h fr=%0d",
               nm, sc_a, cl_a, mx_a, fr_a, e.sc, e.cs, e.ms, e.fr[15:0]);
      bad++;
    end
    total++;
    if (sc_b !== e.sc || cl_b !== e.cu || mx_b !== e.mu || fr_b !== e.fr[1:0]) begin
      $display("FAIL %s unsigned_rec: got sc=%h cls=%0d max=%h fr=%0d want sc=%h cls=%0d max=%h fr=%0d",
               nm, sc_b, cl_b, mx_b, fr_b, e.sc, e.cu, e.mu, e.fr[1:0]);
      bad++;
    end
    if (rrdy) begin
      tick();
      total++;
      if (vl_a !== 1'b0 || vl_b !== 1'b0 || busy_a !== 1'b0) begin
        $display("FAIL %s after_hs: got valid=%b/%b busy=%b want 0/0 0", nm, vl_a, vl_b, busy_a);
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rrdy  = 1'b1;
    tv    = '0;
    for (int i = 0; i < 5; i++) td[i] = '0;
    tick();
    tick();
    total++;
    if (trdy_a !== 5'h00 || trdy_b !== 5'h00) begin
      $display("FAIL reset tready: got %b/%b want 00000", trdy_a, trdy_b);
      bad++;
    end
    total++;
    if (vl_a !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0 || sc_a !== '0 ||
        cl_a !== 3'd0 || mx_a !== '0 || fr_a !== 16'd0) begin
      $display("FAIL reset outputs: got v=%b busy=%b sc=%h cls=%0d max=%h fr=%0d want all 0",
               vl_a, busy_a, sc_a, cl_a, mx_a, fr_a);
      bad++;
    end
    reset = 1'b0;
    #1;
    total++;
    if (trdy_a !== 5'h1f || trdy_b !== 5'h1f) begin
      $display("FAIL reset_release tready: got %b/%b want 11111", trdy_a, trdy_b);
      bad++;
    end
  endtask

  task automatic test_all_at_once();
    exp_t e;
    send_all("all", mk(12'd10, 12'd50, 12'hFFD, 12'd20, 12'd7));
    wait_result("all", 4, e);
  endtask

  // ch3 at c=0 and held valid with new data, ch0 at 2, ch4 at 5, ch1/ch2 at 9.
  task automatic test_staggered();
    exp_t e;
    int arr [5] = '{2, 9, 9, 0, 5};
    logic [4:0][W-1:0] s;
    logic [4:0] want;
    s = mk(12'd60, 12'hFEC, 12'd300, 12'd40, 12'd300);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 5; i++) begin
        tv[i]   = (arr[i] == c) || (i == 3);
        td[i]   = (i == 3 && c > 0) ? 12'h777 : s[i];
        want[i] = !(arr[i] < c);
      end
      #1;
      total++;
      if (trdy_a !== want) begin
        $display("FAIL stagger tready c=%0d: got %b want %b", c, trdy_a, want);
        bad++;
      end
      tick();
    end
    tv = '0;
    push_frame(s);
    wait_result("stagger", 4, e);
  endtask

  task automatic test_tie();
    exp_t e;
    send_all("tie", mk(12'd5, 12'd9, 12'd9, 12'd9, 12'd1));
    wait_result("tie", 4, e);
  endtask

  task automatic test_sign();
    exp_t e;
    send_all("sign", mk(12'h800, 12'hFFF, 12'h7FF, 12'h000, 12'h001));
    wait_result("sign", 4, e);
  endtask

  task automatic test_backpressure();
    exp_t cur, e;
    logic [4:0][W-1:0] s2;
    s2 = mk(12'd3, 12'd1, 12'd4, 12'd1, 12'd5);
    rrdy = 1'b0;
    send_all("bp1", mk(12'd11, 12'd22, 12'd33, 12'd44, 12'd55));
    wait_result("bp1", 4, cur);
    for (int i = 0; i < 5; i++) td[i] = s2[i];
    tv = 5'h1f;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (vl_a !== 1'b1 || sc_a !== cur.sc || cl_a !== cur.cs || mx_a !== cur.ms ||
          fr_a !== cur.fr[15:0] || trdy_a !== 5'h00) begin
        $display("FAIL bp_hold c=%0d: got v=%b cls=%0d max=%h fr=%0d trdy=%b want v=1 cls=%0d max=%h fr=%0d trdy=00000",
                 c, vl_a, cl_a, mx_a, fr_a, trdy_a, cur.cs, cur.ms, cur.fr[15:0]);
        bad++;
      end
      tick();
    end
    rrdy = 1'b1;
    tick();
    total++;
    if (trdy_a !== 5'h1f || vl_a !== 1'b0) begin
      $display("FAIL bp_release: got trdy=%b v=%b want 11111 0", trdy_a, vl_a);
      bad++;
    end
    tick();
    tv = '0;
    push_frame(s2);
    wait_result("bp2", 4, e);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int i = 0; i < 5; i++) td[i] = 12'(i + 1);
    tv = 5'b00111;
    #1;
    tick();
    tv = '0;
    total++;
    if (busy_a !== 1'b1 || trdy_a !== 5'b11000) begin
      $display("FAIL midrst partial: got busy=%b trdy=%b want 1 11000", busy_a, trdy_a);
      bad++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (trdy_a !== 5'h00 || trdy_b !== 5'h00) begin
      $display("FAIL midrst tready: got %b/%b want 00000", trdy_a, trdy_b);
      bad++;
    end
    tick();
    total++;
    if (busy_a !== 1'b0 || vl_a !== 1'b0 || sc_a !== '0 || cl_a !== 3'd0 || mx_a !== '0 || fr_a !== 16'd0) begin
      $display("FAIL midrst clear: got busy=%b v=%b sc=%h cls=%0d max=%h fr=%0d want all 0",
               busy_a, vl_a, sc_a, cl_a, mx_a, fr_a);
      bad++;
    end
    reset = 1'b0;
    frame_no = 0;
    sb.delete();
    send_all("midrst", mk(12'd7, 12'd8, 12'd9, 12'hF00, 12'd2));
    wait_result("midrst", 4, e);
  endtask

  // Drop a pending record with reset, then five frames to see the counter wrap.
  task automatic test_wrap();
    exp_t e;
    logic [4:0][W-1:0] s;
    rrdy = 1'b0;
    send_all("out_rst", mk(12'd1, 12'd2, 12'd3, 12'd4, 12'd5));
    wait_result("out_rst", 4, e);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rrdy = 1'b1;
    frame_no = 0;
    #1;
    total++;
    if (vl_a !== 1'b0 || vl_b !== 1'b0 || trdy_a !== 5'h1f) begin
      $display("FAIL out_rst drop: got v=%b/%b trdy=%b want 0/0 11111", vl_a, vl_b, trdy_a);
      bad++;
    end
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 5; i++) s[i] = 12'($urandom_range(0, 4095));
      send_all("wrap", s);
      wait_result("wrap", 4, e);
    end
  endtask

  initial begin
    test_reset();
    test_all_at_once();
    test_staggered();
    test_tie();
    test_sign();
    test_backpressure();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cnn_score_collector.md
Name: cnn_score_collector

Overview:
- Sink at the far end of the CNN classifier output interface. Consumes the five independent per-class score streams (cnn_output_0..4) produced by the crop-plus-CNN top level.
- Captures exactly one score per class per frame and computes the argmax with a sequential comparator.
- Emits one packed result record per frame on a single valid/ready output, with a frame counter for downstream logging and DMA.

Parameters:
- PIXEL_BIT_WIDTH, 12, width of each class score (same as the CNN output TDATA width).
- SIGNED_SCORES, 1, 1 = scores compared as two's complement, 0 = unsigned.
- FRAME_CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cnn_output_k_TDATA (k=0..4)  in  PIXEL_BIT_WIDTH  class k score
- cnn_output_k_TVALID (k=0..4)  in  1  class k score valid
- cnn_output_k_TREADY (k=0..4)  out  1  class k score accepted
- result_scores_TDATA  out  5*PIXEL_BIT_WIDTH  packed scores; class 0 in the LSBs
- result_class_TDATA  out  3  argmax index, 0..4
- result_max_TDATA  out  PIXEL_BIT_WIDTH  winning score
- result_frame_TDATA  out  FRAME_CNT_WIDTH  frame index of this record
- result_TVALID  out  1  result record valid
- result_TREADY  in  1  downstream accepts the record
- busy  out  1  high when not in COLLECT, or when any capture flag is set

Behaviour:
- Reset values: state=COLLECT, all capture flags=0, all score registers=0, frame counter=0, result_TVALID=0, all result data=0, busy=0.
- cnn_output_k_TREADY = ~reset & (state==COLLECT) & ~flag_k. It is low in the reset cycle and high from the first cycle after reset.
- State COLLECT:
  - A handshake on channel k (TVALID & TREADY at the edge) latches TDATA into score_k and sets flag_k.
  - Channels are independent. Any subset, including all five, may complete in the same cycle.
  - A channel that has already been captured keeps TREADY low. Its upstream must hold the data, so a second score for the same class is never overwritten or dropped.
  - On the edge where all five flags become set (counting captures in that same cycle): state←ARGMAX, best_idx←0, best_val←score_0 (or the incoming data when class 0 is captured on that edge), scan_idx←1.
- State ARGMAX:
  - One compare per cycle for scan_idx = 1..4: if score_scan > best_val (strictly greater), update best_idx and best_val.
  - Compare is signed or unsigned per SIGNED_SCORES.
  - Ties resolve to the lowest index.
  - On the edge that processes scan_idx=4: state←OUT, and the result registers load.
  - Latency: result_TVALID is high after exactly 4 edges following the last capture edge.
- State OUT:
  - result_TVALID=1. All result_* outputs stay stable until result_TREADY is sampled high.
  - On that handshake edge: flags←0, frame counter←frame+1 (wraps modulo 2^FRAME_CNT_WIDTH), result_TVALID←0, state←COLLECT.
  - Input TREADYs are low throughout ARGMAX and OUT, so the next frame's scores are back-pressured and none are lost.
- result_frame_TDATA carries the counter value before the increment, so the first record reports frame 0.
- Reset mid-operation, in any state: return to reset values on the next edge. Partially captured scores are discarded. Any record pending in OUT is dropped and the frame counter is cleared.
- Score registers are not cleared between frames. Only the flags gate validity.

Test Plan:
- All five valid in one cycle with scores 10,50,-3,20,7 (signed) → every TREADY high for that single cycle; result_TVALID high 4 cycles later; class=1, max=50, frame=0.
- Staggered arrival (ch3 at t, ch0 at t+2, ch4 at t+5, ch1/ch2 at t+9) with ch3 TVALID held high → ch3 TREADY low after its capture with no second capture; result 4 cycles after t+9.
- Tie: scores 5,9,9,9,1 → class=1, max=9.
- SIGNED_SCORES=1: scores 0x800,0xFFF,0x7FF,0,1 (12-bit) → class=2, max=0x7FF. SIGNED_SCORES=0 with the same data → class=1, max=0xFFF.
- Backpressure: result_TREADY low for 10 cycles → outputs held constant with TVALID high; the next frame's inputs see TREADY=0 until the handshake, then frame=1 on the following record.
- reset pulsed after 3 of 5 captures → all TREADY low during the reset cycle, then high; a full new frame produces frame=0. With FRAME_CNT_WIDTH=2, five frames report 0,1,2,3,0.
